prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter DEB_CYCLES, default 4, is the number of consecutive stable clk samples needed to accept a key level (synthesis builds set 2048000).
REQ-002 Parameter ADDR_W, default 16, is the load address width.
REQ-003 Port clk, input, 1, is the single clock (same clock as the memory it feeds).
REQ-004 Port rst, input, 1, is an asynchronous, active-low reset.
REQ-005 Port load_en, input, 1, is high when the CPU state selects program-load mode.
REQ-006 Port A1, input, 1, is the raw (bouncing) active-high store key.
REQ-007 Port D, input, 8, is the switch data byte to store.
REQ-008 Port addr, output, ADDR_W, is the memory address being loaded.
REQ-009 Port data_out, output, 8, is the byte driven to memory.
REQ-010 Port write, output, 1, is the one-cycle memory write strobe.
REQ-011 Port check_in, input, 8, is the memory readback byte at addr.
REQ-012 Port busy, output, 1, is high in any non-IDLE state.
REQ-013 Port err, output, 1, is a sticky readback-mismatch flag.
REQ-014 Port wrap, output, 1, is a sticky flag set when addr rolls over.
REQ-015 Port count, output, 8, is the number of bytes stored since reset, saturating at 255.

Function
REQ-016 A1 SHALL pass a 2-flop synchronizer, then a debounce counter; the debounced level changes only after DEB_CYCLES equal consecutive synchronized samples.
REQ-017 A debounced rising edge SHALL be a one-cycle press pulse; holding the key SHALL NOT auto-repeat.
REQ-018 The FSM SHALL have the states IDLE, WRITE, READBACK and ADVANCE.
REQ-019 IDLE->WRITE on a press pulse with load_en=1; presses while load_en=0 or busy=1 SHALL be ignored.
REQ-020 On entry to WRITE, D SHALL be latched into data_out; write=1 for exactly that cycle; addr is unchanged.
REQ-021 WRITE->READBACK unconditionally, then READBACK->ADVANCE after one cycle; in READBACK, check_in!=data_out SHALL set err.
REQ-022 In ADVANCE, addr SHALL increment by 1 modulo 2^ADDR_W, count SHALL increment (saturating), and the FSM SHALL return to IDLE.
REQ-023 addr rolling from all-ones to 0 SHALL set wrap; loading continues from 0.
REQ-024 A press-to-write latency of DEB_CYCLES+3 clk cycles from the first stable A1 sample SHALL hold.
REQ-025 If load_en falls in WRITE or READBACK, the current byte SHALL complete through ADVANCE before IDLE.
REQ-026 load_en rising from 0 SHALL clear addr to 0; err, wrap and count are unaffected.
REQ-027 write SHALL never be high in two consecutive cycles.

Reset
REQ-028 With rst=0, outputs SHALL go to: addr=0, data_out=0, write=0, busy=0, err=0, wrap=0, count=0; the FSM goes to IDLE; synchronizer and debounce state go to 0.
REQ-029 Reset asserted mid-operation SHALL abort the byte without a write pulse after assertion.
REQ-030 A1 held high across reset release SHALL NOT produce a press until released and pressed again.

Structure
REQ-031 The FSM state encoding and the DEB_CYCLES simulation and synthesis constants SHALL live in the shared CPU package alongside the clk_div symbol constants.
REQ-032 The debounce logic SHALL be one sub-module, key_debounce (synchronizer, counter, rising-edge pulse), reusable for the SW1 and SW2 inputs.

Verification
REQ-033 Scenario 1: reset, load_en=1, D=8'h3C, clean A1 press -> one write pulse at addr=0 with data_out=8'h3C, then addr=1 and count=1.
REQ-034 Scenario 2: an A1 bounce of 3-cycle glitches with DEB_CYCLES=4, followed by a stable press -> exactly one write.
REQ-035 Scenario 3: addr preloaded by 65535 presses to 16'hFFFF, one more press -> write at 16'hFFFF, then addr=0 and wrap=1.
REQ-036 Scenario 4: check_in forced to 8'h00 while D=8'h5A -> err=1 after READBACK, and err stays 1 after subsequent good writes.
REQ-037 Scenario 5: rst pulsed low in the WRITE cycle -> all outputs reach their reset values immediately, no further write, and A1 held high yields no press.
REQ-038 Scenario 6: press with load_en=0 -> no write; load_en toggled 0->1 after 3 loads -> addr=0 and count=3.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared CPU package: load FSM encoding, key debounce constants, clk_div symbol
// constants and small arithmetic helpers.
package prog_loader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WRITE    = 2'd1,
      ST_READBACK = 2'd2,
      ST_ADVANCE  = 2'd3
   } load_state_e;

   localparam int DEB_CYCLES_SIM = 4;
   localparam int DEB_CYCLES_SYN = 2048000;

   localparam int CLK_DIV_SYM_SIM = 16;
   localparam int CLK_DIV_SYM_SYN = 5208;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/prog_loader_key_debounce.sv
// Key debouncer: 2-flop synchronizer, run-length stability counter and a
// one-cycle pulse on each accepted rising level (armed only after a stable low).
module key_debounce #(
   parameter int DEB_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic key,
   output logic press
);

   localparam int             CW      = $clog2(DEB_CYCLES + 1);
   localparam logic [CW-1:0]  RUN_MAX = CW'(DEB_CYCLES);
   localparam logic [CW-1:0]  RUN_ONE = CW'(1);

   logic          sync1_r;
   logic          sync2_r;
   logic          last_r;
   logic [CW-1:0] run_r;
   logic [CW-1:0] run_next_s;
   logic          level_r;
   logic          level_prev_r;
   logic          armed_r;
   logic          press_r;

   // Length of the current run of identical synchronized samples, saturating.
   always_comb begin
      run_next_s = run_r;
      if (sync2_r != last_r) begin
         run_next_s = RUN_ONE;
      end else if (run_r == RUN_MAX) begin
         run_next_s = RUN_MAX;
      end else begin
         run_next_s = run_r + RUN_ONE;
      end
   end

   // Synchronizer, level acceptance and edge pulse; a key held through reset
   // cannot arm, so it never produces a press until released first.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_r      <= 1'b0;
         sync2_r      <= 1'b0;
         last_r       <= 1'b0;
         run_r        <= {CW{1'b0}};
         level_r      <= 1'b0;
         level_prev_r <= 1'b0;
         armed_r      <= 1'b0;
         press_r      <= 1'b0;
      end else begin
         sync1_r      <= key;
         sync2_r      <= sync1_r;
         last_r       <= sync2_r;
         run_r        <= run_next_s;
         if (run_next_s == RUN_MAX) begin
            level_r <= sync2_r;
            if (!sync2_r) begin
               armed_r <= 1'b1;
            end
         end
         level_prev_r <= level_r;
         press_r      <= level_r & ~level_prev_r & armed_r;
      end
   end

   assign press = press_r;

endmodule

// File: rtl/prog_loader.sv
// Front-panel program loader: each debounced store-key press writes the switch
// byte to memory, verifies it by readback and advances the load address.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int DEB_CYCLES = DEB_CYCLES_SIM,
   parameter int ADDR_W     = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_en,
   input  logic              A1,
   input  logic [7:0]        D,
   output logic [ADDR_W-1:0] addr,
   output logic [7:0]        data_out,
   output logic              write,
   input  logic [7:0]        check_in,
   output logic              busy,
   output logic              err,
   output logic              wrap,
   output logic [7:0]        count
);

   localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
   localparam logic [ADDR_W-1:0] ADDR_ONES = {ADDR_W{1'b1}};
   localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

   load_state_e       state_r;
   logic [ADDR_W-1:0] addr_r;
   logic [7:0]        data_out_r;
   logic              write_r;
   logic              busy_r;
   logic              err_r;
   logic              wrap_r;
   logic [7:0]        count_r;
   logic              load_en_prev_r;
   logic              press_s;
   logic              load_rise_s;

   key_debounce #(
      .DEB_CYCLES (DEB_CYCLES)
   ) u_key_a1 (
      .clk   (clk),
      .rst   (rst),
      .key   (A1),
      .press (press_s)
   );

   assign load_rise_s = load_en & ~load_en_prev_r;

   // Load FSM with all outputs registered; a byte in flight always finishes
   // through ADVANCE even if load_en drops.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r        <= ST_IDLE;
         addr_r         <= ADDR_ZERO;
         data_out_r     <= 8'h00;
         write_r        <= 1'b0;
         busy_r         <= 1'b0;
         err_r          <= 1'b0;
         wrap_r         <= 1'b0;
         count_r        <= 8'h00;
         load_en_prev_r <= 1'b0;
      end else begin
         load_en_prev_r <= load_en;
         write_r        <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (press_s && load_en) begin
                  state_r    <= ST_WRITE;
                  data_out_r <= D;
                  write_r    <= 1'b1;
                  busy_r     <= 1'b1;
               end
            end
            ST_WRITE: begin
               state_r <= ST_READBACK;
            end
            ST_READBACK: begin
               if (check_in != data_out_r) begin
                  err_r <= 1'b1;
               end
               state_r <= ST_ADVANCE;
            end
            ST_ADVANCE: begin
               if (addr_r == ADDR_ONES) begin
                  wrap_r <= 1'b1;
               end
               addr_r  <= addr_r + ADDR_ONE;
               count_r <= sat_inc8(count_r);
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
         // Re-entering load mode restarts loading at address zero.
         if (load_rise_s) begin
            addr_r <= ADDR_ZERO;
         end
      end
   end

   assign addr     = addr_r;
   assign data_out = data_out_r;
   assign write    = write_r;
   assign busy     = busy_r;
   assign err      = err_r;
   assign wrap     = wrap_r;
   assign count    = count_r;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader with a write scoreboard and a small memory model.
module tb_prog_loader;

   localparam int DEB = 4;
   localparam int AW  = 4;
   localparam logic [AW-1:0] A_ONES = {AW{1'b1}};

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          load_en = 1'b0;
   logic          A1 = 1'b0;
   logic [7:0]    D = 8'h00;
   logic [AW-1:0] addr;
   logic [7:0]    data_out;
   logic          write;
   logic [7:0]    check_in;
   logic          busy;
   logic          err;
   logic          wrap;
   logic [7:0]    count;

   logic [7:0]    mem [0:(1<<AW)-1];
   logic          force_bad = 1'b0;
   logic          prev_write = 1'b0;
   logic [AW+7:0] sb_q [$];
   logic [AW+7:0] mon_e;
   logic [AW-1:0] exp_addr = '0;
   logic [7:0]    exp_count = 8'h00;
   int            n_tests = 0;
   int            n_fail = 0;
   int            n_writes = 0;
   int            lat;
   int            w0;

   prog_loader #(.DEB_CYCLES(DEB), .ADDR_W(AW)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .load_en  (load_en),
      .A1       (A1),
      .D        (D),
      .addr     (addr),
      .data_out (data_out),
      .write    (write),
      .check_in (check_in),
      .busy     (busy),
      .err      (err),
      .wrap     (wrap),
      .count    (count)
   );

   always #5 clk = ~clk;

   assign check_in = force_bad ? 8'h00 : mem[addr];

   always @(posedge clk) begin
      if (write) mem[addr] <= data_out;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst && write) begin
         n_writes++;
         chk("no_consecutive_write", 32'(prev_write), 32'd0);
         chk("write_expected", 32'(sb_q.size() > 0), 32'd1);
         if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            chk("write_addr", 32'(addr), 32'(mon_e[AW+7:8]));
            chk("write_data", 32'(data_out), 32'(mon_e[7:0]));
         end
      end
      prev_write = write;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_write(output int l);
      l = 0;
      @(posedge clk); #1;
      while (!write && l < 40) begin
         l++;
         @(posedge clk); #1;
      end
   endtask

   task automatic press(input logic expect_wr);
      if (expect_wr) sb_q.push_back({exp_addr, D});
      A1 = 1'b1;
      tick(DEB + 8);
      A1 = 1'b0;
      tick(DEB + 6);
      if (expect_wr) begin
         exp_addr = exp_addr + 1'b1;
         if (exp_count != 8'hFF) exp_count = exp_count + 8'd1;
      end
   endtask

   initial begin
      for (int i = 0; i < (1<<AW); i++) mem[i] = 8'h00;
      tick(3);
      chk("rst_addr", 32'(addr), 32'd0);
      chk("rst_data_out", 32'(data_out), 32'd0);
      chk("rst_write", 32'(write), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_wrap", 32'(wrap), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      rst = 1'b1;
      tick(6);

      // clean press with latency measurement
      load_en = 1'b1;
      tick(2);
      D = 8'h3C;
      sb_q.push_back({exp_addr, D});
      A1 = 1'b1;
      wait_write(lat);
      chk("press_to_write_latency", 32'(lat), 32'(DEB + 3));
      tick(6);
      A1 = 1'b0;
      tick(DEB + 6);
      exp_addr = exp_addr + 1'b1;
      exp_count = exp_count + 8'd1;
      chk("s1_addr", 32'(addr), 32'd1);
      chk("s1_count", 32'(count), 32'd1);
      chk("s1_busy", 32'(busy), 32'd0);
      chk("s1_err", 32'(err), 32'd0);

      // 3-cycle glitches must not be accepted
      w0 = n_writes;
      D = 8'hA5;
      for (int i = 0; i < 3; i++) begin
         A1 = 1'b1;
         tick(3);
         A1 = 1'b0;
         tick(3);
      end
      chk("bounce_no_write", 32'(n_writes - w0), 32'd0);
      press(1'b1);
      chk("bounce_single_write", 32'(n_writes - w0), 32'd1);
      chk("s2_addr", 32'(addr), 32'(exp_addr));

      // readback mismatch is sticky
      force_bad = 1'b1;
      D = 8'h5A;
      press(1'b1);
      chk("err_set", 32'(err), 32'd1);
      force_bad = 1'b0;
      D = 8'h81;
      press(1'b1);
      chk("err_sticky", 32'(err), 32'd1);
      chk("s4_count", 32'(count), 32'(exp_count));

      // fill up to the all-ones address, then roll over
      for (int i = 0; i < (1<<AW) && exp_addr != A_ONES; i++) begin
         D = 8'(exp_addr) ^ 8'hC3;
         press(1'b1);
      end
      chk("pre_wrap_addr", 32'(addr), 32'(A_ONES));
      chk("pre_wrap_flag", 32'(wrap), 32'd0);
      D = 8'hE7;
      press(1'b1);
      chk("wrap_addr", 32'(addr), 32'd0);
      chk("wrap_flag", 32'(wrap), 32'd1);
      chk("wrap_count", 32'(count), 32'(exp_count));

      // reset in the WRITE cycle with the key held
      A1 = 1'b1;
      wait_write(lat);
      chk("s5_write_seen", 32'(write), 32'd1);
      rst = 1'b0;
      #1;
      chk("s5_write", 32'(write), 32'd0);
      chk("s5_addr", 32'(addr), 32'd0);
      chk("s5_data_out", 32'(data_out), 32'd0);
      chk("s5_busy", 32'(busy), 32'd0);
      chk("s5_err", 32'(err), 32'd0);
      chk("s5_wrap", 32'(wrap), 32'd0);
      chk("s5_count", 32'(count), 32'd0);
      exp_addr = '0;
      exp_count = 8'h00;
      tick(2);
      rst = 1'b1;
      w0 = n_writes;
      tick(30);
      chk("held_key_no_press", 32'(n_writes - w0), 32'd0);
      chk("held_key_busy", 32'(busy), 32'd0);
      A1 = 1'b0;
      tick(DEB + 6);

      // presses ignored outside load mode; re-entry clears addr only
      load_en = 1'b0;
      tick(2);
      w0 = n_writes;
      D = 8'h99;
      press(1'b0);
      chk("no_load_no_write", 32'(n_writes - w0), 32'd0);
      load_en = 1'b1;
      tick(2);
      D = 8'h11;
      press(1'b1);
      D = 8'h22;
      press(1'b1);
      D = 8'h33;
      sb_q.push_back({exp_addr, D});
      A1 = 1'b1;
      wait_write(lat);
      chk("s6_third_write", 32'(write), 32'd1);
      load_en = 1'b0;
      tick(6);
      exp_addr = exp_addr + 1'b1;
      exp_count = exp_count + 8'd1;
      chk("drop_load_completes_addr", 32'(addr), 32'(exp_addr));
      chk("drop_load_busy", 32'(busy), 32'd0);
      A1 = 1'b0;
      tick(DEB + 6);
      load_en = 1'b1;
      tick(2);
      chk("reenter_addr", 32'(addr), 32'd0);
      chk("reenter_count", 32'(count), 32'd3);
      chk("reenter_err", 32'(err), 32'd0);
      chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
